// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - PS/2 frame receiver with glitch filtering, timeout and FWFT receive FIFO
module ps2_rx_fifo #(
   parameter int WIDTH   = 8,
   parameter int PARITY  = 1,
   parameter int DEPTH   = 4,
   parameter int FILTER  = 4,
   parameter int TIMEOUT = 1024
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             kclk,
   input  logic             kdat,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_valid,
   input  logic             rd_ready,
   output logic             err_parity,
   output logic             err_frame,
   output logic             overflow,
   output logic             busy
);

   localparam int AW = $clog2(DEPTH);
   localparam int FW = $clog2(FILTER + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, DATA, PAR, STOP} state_t;

   // index 0 carries kclk, index 1 carries kdat
   logic [1:0]    s1, s2, filt;
   logic [FW-1:0] fcnt [2];
   logic          filt_clk_d;
   logic          fall, bit_in;

   state_t           state, state_nx;
   logic             shift, par_chk, fin, tout;
   logic [4:0]       bitcnt;
   logic [TW-1:0]    tcnt;
   logic [WIDTH-1:0] shreg, push_data;
   logic [WIDTH:0]   sh_tmp;
   logic             par_bad, push_req;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr, rptr;
   logic [AW:0]      count;
   logic             full, pop, wr;

   always_ff @(posedge clk) begin
      if (reset) begin
         s1         <= 2'b11;
         s2         <= 2'b11;
         filt       <= 2'b11;
         filt_clk_d <= 1'b1;
         fcnt[0]    <= '0;
         fcnt[1]    <= '0;
      end else begin
         s1         <= {kdat, kclk};
         s2         <= s1;
         filt_clk_d <= filt[0];
         // a new level is accepted only after FILTER consecutive differing samples
         for (int i = 0; i < 2; i++) begin
            if (s2[i] == filt[i]) begin
               fcnt[i] <= '0;
            end else if (fcnt[i] == FW'(FILTER - 1)) begin
               filt[i] <= s2[i];
               fcnt[i] <= '0;
            end else begin
               fcnt[i] <= fcnt[i] + 1'b1;
            end
         end
      end
   end

   assign fall   = filt_clk_d & ~filt[0];
   assign bit_in = filt[1];
   assign tout   = (state != IDLE) && !fall && (tcnt == TW'(TIMEOUT - 1));
   assign sh_tmp = {bit_in, shreg};

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      shift    = 1'b0;
      par_chk  = 1'b0;
      fin      = 1'b0;
      case (state)
         IDLE: if (fall && !bit_in) state_nx = DATA;
         DATA: if (fall) begin
            shift = 1'b1;
            if (bitcnt == 5'(WIDTH - 1)) state_nx = (PARITY != 0) ? PAR : STOP;
         end
         PAR: if (fall) begin
            par_chk  = 1'b1;
            state_nx = STOP;
         end
         STOP: if (fall) begin
            fin      = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
      if (tout) state_nx = IDLE;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bitcnt     <= '0;
         tcnt       <= '0;
         shreg      <= '0;
         par_bad    <= 1'b0;
         push_req   <= 1'b0;
         push_data  <= '0;
         err_parity <= 1'b0;
         err_frame  <= 1'b0;
      end else begin
         push_req   <= 1'b0;
         err_parity <= 1'b0;
         err_frame  <= tout;
         if (state == IDLE || fall) tcnt <= '0;
         else                       tcnt <= tcnt + 1'b1;
         if (state == IDLE) begin
            bitcnt  <= '0;
            par_bad <= 1'b0;
         end
         if (shift) begin
            shreg  <= sh_tmp[WIDTH:1];
            bitcnt <= bitcnt + 1'b1;
         end
         if (par_chk) par_bad <= (PARITY == 1) ? (bit_in != ~^shreg) : (bit_in != ^shreg);
         // stop-bit error wins over a latched parity failure
         if (fin) begin
            if (!bit_in)      err_frame  <= 1'b1;
            else if (par_bad) err_parity <= 1'b1;
            else begin
               push_req  <= 1'b1;
               push_data <= shreg;
            end
         end
      end
   end

   assign full     = (count == (AW + 1)'(DEPTH));
   assign rd_valid = (count != '0);
   assign pop      = rd_valid && rd_ready;
   assign wr       = push_req && (!full || pop);
   assign overflow = push_req && full && !pop;
   assign rd_data  = rd_valid ? mem[rptr] : '0;
   assign busy     = (state != IDLE);

   always_ff @(posedge clk) begin
      if (wr) mem[wptr] <= push_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (wr)  wptr <= wptr + 1'b1;
         if (pop) rptr <= rptr + 1'b1;
         count <= count + (AW + 1)'(wr) - (AW + 1)'(pop);
      end
   end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb/tb_ps2_rx_fifo.sv - self-checking bench for ps2_rx_fifo (default and 9-bit no-parity instances)
module tb_ps2_rx_fifo;

   logic       clk = 1'b0, reset = 1'b1, kclk = 1'b1, kdat = 1'b1, rdy = 1'b1, rdy9 = 1'b1;
   logic [7:0] rd_data;
   logic       rd_valid, err_parity, err_frame, overflow, busy;
   logic [8:0] rd_data9;
   logic       rd_valid9, err_parity9, err_frame9, overflow9, busy9;

   ps2_rx_fifo u_dut (
      .clk(clk), .reset(reset), .kclk(kclk), .kdat(kdat),
      .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rdy),
      .err_parity(err_parity), .err_frame(err_frame), .overflow(overflow), .busy(busy)
   );

   ps2_rx_fifo #(.WIDTH(9), .PARITY(0)) u_dut9 (
      .clk(clk), .reset(reset), .kclk(kclk), .kdat(kdat),
      .rd_data(rd_data9), .rd_valid(rd_valid9), .rd_ready(rdy9),
      .err_parity(err_parity9), .err_frame(err_frame9), .overflow(overflow9), .busy(busy9)
   );

   always #5 clk = ~clk;

   int total = 0, passed = 0;
   int n_perr = 0, n_ferr = 0, n_ovf = 0, n9_perr = 0, n9_ferr = 0;
   logic [15:0] got[$], got9[$];

   always @(negedge clk) begin
      n_perr  <= n_perr + int'(err_parity);
      n_ferr  <= n_ferr + int'(err_frame);
      n_ovf   <= n_ovf + int'(overflow);
      n9_perr <= n9_perr + int'(err_parity9);
      n9_ferr <= n9_ferr + int'(err_frame9);
      if (rd_valid && rdy) got.push_back(16'(rd_data));
      if (rd_valid9 && rdy9) got9.push_back(16'(rd_data9));
   end

   typedef struct {
      logic [7:0] d;
      bit         pb;
      bit         sb;
      int         exp;   // 0 pushed, 1 parity error, 2 frame error
   } vec_t;

   vec_t tbl[8];

   task automatic chk(string nm, int act, int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   task automatic cyc(int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic bit odd_par(logic [15:0] d, int w);
      int ones = 0;
      for (int i = 0; i < w; i++) ones += int'(d[i]);
      return (ones % 2) == 0;
   endfunction

   function automatic int outcome(logic [15:0] d, bit pb, bit sb);
      if (!sb) return 2;
      if (pb != odd_par(d, 8)) return 1;
      return 0;
   endfunction

   task automatic send_bit(bit b, int half, bit glitch);
      kdat = b;
      if (glitch) begin
         cyc(5);
         kclk = 1'b0;
         cyc(3);
         kclk = 1'b1;
         cyc(half - 8);
      end else begin
         cyc(half);
      end
      kclk = 1'b0;
      cyc(half);
      kclk = 1'b1;
   endtask

   task automatic send_frame(logic [15:0] d, int w, bit haspar, bit pb, bit sb, int half, bit glitch);
      send_bit(1'b0, half, glitch);
      for (int i = 0; i < w; i++) send_bit(d[i], half, glitch);
      if (haspar) send_bit(pb, half, glitch);
      send_bit(sb, half, glitch);
      kdat = 1'b1;
      cyc(half + 10);
   endtask

   task automatic run_frame(string nm, logic [15:0] d, bit pb, bit sb, int half, bit glitch, int exp);
      int p, f, g;
      p = n_perr; f = n_ferr; g = got.size();
      send_frame(d, 8, 1'b1, pb, sb, half, glitch);
      chk({nm, "_perr"}, n_perr - p, int'(exp == 1));
      chk({nm, "_ferr"}, n_ferr - f, int'(exp == 2));
      chk({nm, "_push"}, got.size() - g, int'(exp == 0));
      if (exp == 0 && got.size() == g + 1) chk({nm, "_data"}, int'(got.pop_back()), int'(d));
      got.delete();
   endtask

   initial begin
      int p, f, o;
      logic [15:0] d;
      bit pb, sb;

      tbl[0] = '{8'hA5, 1'b1, 1'b1, 0};
      tbl[1] = '{8'h3C, 1'b0, 1'b1, 1};
      tbl[2] = '{8'h3C, 1'b1, 1'b0, 2};
      tbl[3] = '{8'h00, 1'b1, 1'b1, 0};
      tbl[4] = '{8'hFF, 1'b1, 1'b1, 0};
      tbl[5] = '{8'h01, 1'b0, 1'b1, 0};
      tbl[6] = '{8'h80, 1'b1, 1'b1, 1};
      tbl[7] = '{8'h7F, 1'b1, 1'b0, 2};

      reset = 1'b1;
      cyc(3);
      chk("rst_valid", int'(rd_valid), 0);
      chk("rst_data", int'(rd_data), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_perr", int'(err_parity), 0);
      chk("rst_ferr", int'(err_frame), 0);
      chk("rst_ovf", int'(overflow), 0);
      reset = 1'b0;
      cyc(20);
      got.delete();

      for (int i = 0; i < 8; i++)
         run_frame($sformatf("tbl%0d", i), 16'(tbl[i].d), tbl[i].pb, tbl[i].sb, 30, 1'b0, tbl[i].exp);

      // fill past depth with the consumer stalled
      rdy = 1'b0;
      p = n_perr; f = n_ferr; o = n_ovf;
      for (int k = 1; k <= 5; k++) send_frame(16'(k), 8, 1'b1, odd_par(16'(k), 8), 1'b1, 20, 1'b0);
      chk("ovf_count", n_ovf - o, 1);
      chk("ovf_errs", (n_perr - p) + (n_ferr - f), 0);
      chk("ovf_valid", int'(rd_valid), 1);
      chk("ovf_head", int'(rd_data), 1);
      rdy = 1'b1;
      cyc(10);
      chk("ovf_drain_n", got.size(), 4);
      for (int i = 0; i < 4 && i < got.size(); i++) chk($sformatf("ovf_drain%0d", i), int'(got[i]), i + 1);
      chk("ovf_empty", int'(rd_valid), 0);
      got.delete();

      // partial frame then silence on kclk
      f = n_ferr;
      send_bit(1'b0, 20, 1'b0);
      for (int i = 0; i < 3; i++) send_bit(1'b1, 20, 1'b0);
      chk("to_busy", int'(busy), 1);
      cyc(1100);
      chk("to_ferr", n_ferr - f, 1);
      chk("to_idle", int'(busy), 0);
      chk("to_nopush", got.size(), 0);
      run_frame("after_to", 16'h12, odd_par(16'h12, 8), 1'b1, 20, 1'b0, 0);

      run_frame("glitch", 16'h5A, odd_par(16'h5A, 8), 1'b1, 20, 1'b1, 0);

      // reset mid-frame with a word still queued
      rdy = 1'b0;
      send_frame(16'h33, 8, 1'b1, odd_par(16'h33, 8), 1'b1, 20, 1'b0);
      chk("pre_rst_valid", int'(rd_valid), 1);
      send_bit(1'b0, 20, 1'b0);
      for (int i = 0; i < 3; i++) send_bit(1'b0, 20, 1'b0);
      chk("pre_rst_busy", int'(busy), 1);
      reset = 1'b1;
      cyc(2);
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_valid", int'(rd_valid), 0);
      chk("mid_rst_data", int'(rd_data), 0);
      reset = 1'b0;
      rdy = 1'b1;
      cyc(10);
      got.delete();
      run_frame("after_rst", 16'h5A, odd_par(16'h5A, 8), 1'b1, 20, 1'b1, 0);

      for (int i = 0; i < 30; i++) begin
         d  = 16'($urandom_range(0, 255));
         pb = odd_par(d, 8);
         if ($urandom_range(0, 3) == 0) pb = ~pb;
         sb = ($urandom_range(0, 4) != 0);
         run_frame($sformatf("rnd%0d", i), d, pb, sb, $urandom_range(12, 30), 1'b0, outcome(d, pb, sb));
      end
      chk("rnd_idle", int'(busy), 0);

      // 9-bit, no-parity instance
      reset = 1'b1;
      cyc(3);
      reset = 1'b0;
      cyc(10);
      got9.delete();
      p = n9_perr; f = n9_ferr;
      send_frame(16'h1FF, 9, 1'b0, 1'b0, 1'b1, 20, 1'b0);
      chk("w9_push", got9.size(), 1);
      if (got9.size() == 1) chk("w9_data", int'(got9[0]), 16'h1FF);
      chk("w9_ferr_ok", n9_ferr - f, 0);
      got9.delete();
      send_frame(16'h1FF, 9, 1'b0, 1'b0, 1'b0, 20, 1'b0);
      chk("w9_ferr", n9_ferr - f, 1);
      chk("w9_nopush", got9.size(), 0);
      chk("w9_perr", n9_perr - p, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/ps2_rx_fifo.md
PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

Interface
REQ-001 Parameter WIDTH, default 8, data bits per frame (1..16).
REQ-002 Parameter PARITY, default 1, parity mode: 0 none, 1 odd, 2 even.
REQ-003 Parameter DEPTH, default 4, receive FIFO entries (power of two, >=2).
REQ-004 Parameter FILTER, default 4, consecutive equal samples required to accept a line change on kclk/kdat.
REQ-005 Parameter TIMEOUT, default 1024, clk cycles without a kclk falling edge before an in-progress frame is aborted.
REQ-006 clk  input  1  system clock; one clock domain, all state updates on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 kclk  input  1  asynchronous serial clock line, idle high.
REQ-009 kdat  input  1  asynchronous serial data line, idle high.
REQ-010 rd_data  output  WIDTH  head-of-FIFO data, first-word-fall-through.
REQ-011 rd_valid  output  1  FIFO not empty.
REQ-012 rd_ready  input  1  consumer accepts rd_data when rd_valid&&rd_ready.
REQ-013 err_parity  output  1  one-cycle pulse: frame discarded for bad parity.
REQ-014 err_frame  output  1  one-cycle pulse: frame discarded for bad stop bit or timeout.
REQ-015 overflow  output  1  one-cycle pulse: good frame dropped because FIFO full.
REQ-016 busy  output  1  receiver FSM not in IDLE.

Function
REQ-017 kclk and kdat each SHALL pass a 2-flop synchronizer, then a glitch filter whose output changes only after FILTER consecutive equal synchronized samples; filtered values reset to 1.
REQ-018 A kclk falling edge SHALL be the cycle filtered kclk goes 1->0; filtered kdat SHALL be sampled in that cycle only.
REQ-019 FSM states IDLE, DATA, PAR, STOP; reset state IDLE.
REQ-020 IDLE: falling edge with kdat=0 -> DATA, bit counter 0; kdat=1 ignored, stay IDLE, no error.
REQ-021 DATA: each falling edge shifts kdat in LSB first; after WIDTH bits -> PAR if PARITY!=0, else STOP.
REQ-022 PAR: sampled bit SHALL equal ~^data (odd) or ^data (even); result latched; -> STOP.
REQ-023 STOP: on falling edge -> IDLE; kdat=0 -> err_frame pulse; else parity fail -> err_parity pulse; else push data.
REQ-024 Stop-bit error SHALL take precedence over parity error; at most one error pulse per frame.
REQ-025 Timeout counter SHALL clear on every falling edge and in IDLE; reaching TIMEOUT in any non-IDLE state -> IDLE, err_frame pulse, partial data discarded.
REQ-026 Push SHALL occur in the cycle after the stop-bit falling edge; rd_valid SHALL assert the following cycle if FIFO was empty.
REQ-027 FIFO order SHALL be first-in first-out; pop on rd_valid&&rd_ready; rd_data undefined-but-stable while rd_valid=0.
REQ-028 Push when full with no pop: data dropped, overflow pulse, contents unchanged.
REQ-029 Push and pop in same cycle when full: both performed, no overflow.
REQ-030 Pointers SHALL wrap modulo DEPTH; occupancy counter width clog2(DEPTH)+1.

Reset
REQ-031 reset SHALL, in any state including mid-frame: FSM IDLE, bit/timeout counters 0, FIFO empty, filters and synchronizers to 1.
REQ-032 Outputs during and after reset until next event: rd_valid 0, rd_data 0, err_parity 0, err_frame 0, overflow 0, busy 0.

Verification
REQ-033 Defaults, frame 0xA5 parity 1 stop 1 at 10-16.7 kHz, rd_ready=1 -> one rd_valid beat with rd_data=0xA5, no error pulses.
REQ-034 Frame 0x3C with parity bit 0 -> err_parity pulse once, rd_valid stays 0.
REQ-035 DEPTH=4, rd_ready=0, frames 0x01..0x05 -> overflow pulse on 5th; then rd_ready=1 drains 0x01,0x02,0x03,0x04 in order.
REQ-036 Start bit plus 3 data bits, kclk then held high TIMEOUT cycles -> err_frame pulse, busy falls; next frame 0x12 received intact.
REQ-037 kclk glitches low for FILTER-1 cycles between valid edges of frame 0x5A -> rd_data=0x5A, no errors; reset asserted mid-frame -> busy=0, FIFO empty, next frame received correctly.
REQ-038 WIDTH=9, PARITY=0, frame 0x1FF with stop 1 -> rd_data=0x1FF; same frame with stop 0 -> err_frame, no push.
